yv_row_feeder: RTL

- Upstream feeder for the complex multiply/accumulate datapath of the Jacobi engine.
- For one requested matrix row i, it reads row i of the Y SRAM and the whole V SRAM, one column per cycle.
- It aligns the read data to SRAM latency and streams operand pairs to the complex multiplier inputs (y_feed_mult / v_feed_mult).
- The diagonal operand is diverted to the divider path; its multiplier lane is zeroed so the downstream sum is over j != i.

---
 rtl/yv_row_feeder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/yv_row_feeder.sv
// Row feeder for the Jacobi complex MAC datapath: walks row i of Y and all of V,
// aligns SRAM read data with per-column tags and diverts the diagonal to the divider.
module yv_row_feeder #(
  parameter int unsigned DIM_LOG2 = 3,
  parameter int unsigned DATA_W   = 48,
  parameter int unsigned SRAM_LAT = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DIM_LOG2-1:0]   row_idx,
  output logic                  busy,
  output logic                  done,
  output logic [2*DIM_LOG2-1:0] y_sram_addr,
  output logic [DIM_LOG2-1:0]   v_sram_addr,
  output logic                  sram_rd_en,
  input  logic [DATA_W-1:0]     y_sram_rdata,
  input  logic [DATA_W-1:0]     v_sram_rdata,
  output logic [DATA_W-1:0]     y_feed_mult,
  output logic [DATA_W-1:0]     v_feed_mult,
  output logic                  feed_valid,
  output logic                  feed_last,
  output logic [DATA_W-1:0]     diag_out,
  output logic                  diag_valid
);

  localparam int unsigned DIM = 2 ** DIM_LOG2;
  localparam logic [DIM_LOG2-1:0] ColMax = DIM_LOG2'(DIM - 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  typedef struct packed {
    logic valid;
    logic is_diag;
    logic is_last;
  } tag_t;

  state_e              state_q, state_d;
  logic [DIM_LOG2-1:0] row_q, row_d;
  logic [DIM_LOG2-1:0] col_q, col_d;

  tag_t                tag_in;
  tag_t                tag_out;
  tag_t                tag_q [SRAM_LAT];

  logic [DATA_W-1:0]   y_feed_q;
  logic [DATA_W-1:0]   v_feed_q;
  logic [DATA_W-1:0]   diag_q;
  logic                feed_valid_q;
  logic                feed_last_q;
  logic                diag_valid_q;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          row_d   = row_idx;
          col_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Column stops at DIM-1 so the address holds through drain.
        if (col_q == ColMax) begin
          state_d = StDrain;
        end else begin
          col_d = col_q + DIM_LOG2'(1);
        end
      end
      StDrain: begin
        if (feed_valid_q && feed_last_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign sram_rd_en  = (state_q == StIssue);
  assign busy        = (state_q == StIssue) || (state_q == StDrain);
  assign done        = (state_q == StDone);
  assign y_sram_addr = {row_q, col_q};
  assign v_sram_addr = col_q;

  // ---------------------------------------------------------------------------
  // Tag pipeline, SRAM_LAT deep, so each tag meets its read data
  // ---------------------------------------------------------------------------
  always_comb begin
    tag_in         = '0;
    tag_in.valid   = sram_rd_en;
    tag_in.is_diag = sram_rd_en && (col_q == row_q);
    tag_in.is_last = sram_rd_en && (col_q == ColMax);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SRAM_LAT); i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < int'(SRAM_LAT); i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_out = tag_q[SRAM_LAT-1];

  // ---------------------------------------------------------------------------
  // Registered output stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      y_feed_q     <= '0;
      v_feed_q     <= '0;
      diag_q       <= '0;
      feed_valid_q <= 1'b0;
      feed_last_q  <= 1'b0;
      diag_valid_q <= 1'b0;
    end else begin
      feed_valid_q <= tag_out.valid;
      feed_last_q  <= tag_out.valid && tag_out.is_last;
      diag_valid_q <= tag_out.valid && tag_out.is_diag;
      if (tag_out.valid) begin
        y_feed_q <= y_sram_rdata;
        // Zero the diagonal lane so the downstream sum covers j != i only.
        v_feed_q <= tag_out.is_diag ? '0 : v_sram_rdata;
        if (tag_out.is_diag) begin
          diag_q <= y_sram_rdata;
        end
      end
    end
  end

  assign y_feed_mult = y_feed_q;
  assign v_feed_mult = v_feed_q;
  assign diag_out    = diag_q;
  assign feed_valid  = feed_valid_q;
  assign feed_last   = feed_last_q;
  assign diag_valid  = diag_valid_q;

endmodule
